uart_tx_responder: RTL

Memory-mapped UART transmitter. It responds to the CPU bus handshake (address/data/we/start → busy/q) and is the transmit counterpart of the existing UART receive path. CPU writes are queued in a byte FIFO and serialized onto uart_out as 8N1. A completion interrupt fires when the queue has fully drained.

---
 rtl/uart_tx_responder_pkg.sv | 28 ++
 rtl/uart_tx_responder_fifo.sv | 54 +++++
 rtl/uart_tx_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_responder_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout and the serializer state encoding.
package uart_tx_responder_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_ACTIVE    = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // A divisor below 2 cannot hold a bit on the line, so it is raised to 2.
  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < 16'd2) ? 16'd2 : value;
  endfunction

endpackage

// File: rtl/uart_tx_responder_fifo.sv
// Synchronous first-word-fall-through FIFO. Full is judged before any pop in
// the same cycle, so a push into a full FIFO is always dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter: bus handshake with fixed two-cycle
// latency, byte FIFO, programmable baud divisor and drain interrupt.
module uart_tx_responder
  import uart_tx_responder_pkg::*;
#(
  parameter logic [26:0] BASE_ADDR   = 27'h0C02740,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] address,
  input  logic [31:0] data,
  input  logic        we,
  input  logic        start,
  output logic        busy,
  output logic [31:0] q,
  output logic        uart_out,
  output logic        tx_done_interrupt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            accept;
  logic [1:0]      req_reg;
  logic            req_we;
  logic [15:0]     req_data;
  logic [31:0]     rd_data;
  logic [31:0]     status_word;
  logic            unused_data_bits;

  logic [15:0]     divisor;
  logic            irq_en;
  logic            overflow;

  logic            fifo_push;
  logic            fifo_pop;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  tx_state_t       state, state_next;
  logic [15:0]     baud_cnt, baud_next;
  logic [2:0]      bit_cnt, bit_next;
  logic [7:0]      shift, shift_next;
  logic [15:0]     div_lat, div_next;
  logic            irq_next;
  logic            line_next;

  assign unused_data_bits = ^data[31:16];
  assign accept    = start && !busy && (address[26:2] == BASE_ADDR[26:2]);
  assign fifo_push = busy && req_we && (req_reg == REG_DATA);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (req_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Capture an accepted request; busy lasts exactly one cycle, then q updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      q        <= '0;
      req_reg  <= '0;
      req_we   <= 1'b0;
      req_data <= '0;
    end else begin
      busy <= accept;
      if (accept) begin
        req_reg  <= address[1:0];
        req_we   <= we;
        req_data <= data[15:0];
      end
      if (busy) q <= rd_data;
    end
  end

  // Read mux for the request being serviced; writes always return zero.
  always_comb begin
    status_word                 = '0;
    status_word[STAT_EMPTY]     = fifo_empty;
    status_word[STAT_FULL]      = fifo_full;
    status_word[STAT_ACTIVE]    = (state != TX_IDLE);
    status_word[STAT_OVERFLOW]  = overflow;
    status_word[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
    rd_data = '0;
    if (!req_we) begin
      case (req_reg)
        REG_STATUS: rd_data = status_word;
        REG_DIV:    rd_data = {16'd0, divisor};
        REG_CTRL:   rd_data = {31'd0, irq_en};
        default:    rd_data = '0;
      endcase
    end
  end

  // Configuration registers and the sticky overflow flag (a new drop beats a clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor  <= DEFAULT_DIV;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (fifo_push && fifo_full)
        overflow <= 1'b1;
      else if (busy && !req_we && (req_reg == REG_STATUS))
        overflow <= 1'b0;
      if (busy && req_we && (req_reg == REG_DIV))
        divisor <= clamp_div(req_data);
      if (busy && req_we && (req_reg == REG_CTRL))
        irq_en <= req_data[0];
    end
  end

  // Serializer state register; the line is registered so it never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= TX_IDLE;
      baud_cnt          <= '0;
      bit_cnt           <= '0;
      shift             <= '0;
      div_lat           <= DEFAULT_DIV;
      uart_out          <= 1'b1;
      tx_done_interrupt <= 1'b0;
    end else begin
      state             <= state_next;
      baud_cnt          <= baud_next;
      bit_cnt           <= bit_next;
      shift             <= shift_next;
      div_lat           <= div_next;
      uart_out          <= line_next;
      tx_done_interrupt <= irq_next;
    end
  end

  // Next-state logic; the divisor is sampled only when a start bit begins.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    div_next   = div_lat;
    fifo_pop   = 1'b0;
    irq_next   = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_dout;
          div_next   = divisor;
          baud_next  = divisor - 16'd1;
          state_next = TX_START;
        end
      end
      TX_START: begin
        if (baud_cnt == '0) begin
          baud_next  = div_lat - 16'd1;
          bit_next   = '0;
          state_next = TX_DATA;
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      TX_DATA: begin
        if (baud_cnt == '0) begin
          baud_next  = div_lat - 16'd1;
          shift_next = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) state_next = TX_STOP;
          else                 bit_next   = bit_cnt + 3'd1;
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      TX_STOP: begin
        if (baud_cnt == '0) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_dout;
            div_next   = divisor;
            baud_next  = divisor - 16'd1;
            state_next = TX_START;
          end else begin
            irq_next   = irq_en;
            state_next = TX_IDLE;
          end
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      default: state_next = TX_IDLE;
    endcase
    case (state_next)
      TX_START: line_next = 1'b0;
      TX_DATA:  line_next = shift_next[0];
      default:  line_next = 1'b1;
    endcase
  end

endmodule
